// File: rtl/tipi_rpi_link_ctrl.sv
// tipi_rpi_link_ctrl: RPi serial register link, sequenced in the clk domain.
// Synchronises the RPi strobes and runs the TX/RX transaction FSM for TD/TC/RD/RC.
module tipi_rpi_link_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rpi_sclk,
    input  logic [1:0]       rpi_regsel,
    input  logic             rpi_sdata_out,
    input  logic             rpi_sle,
    output logic             rpi_sdata_in,
    input  logic [WIDTH-1:0] td_in,
    input  logic [WIDTH-1:0] tc_in,
    input  logic             td_strobe,
    input  logic             tc_strobe,
    output logic [WIDTH-1:0] rd_out,
    output logic [WIDTH-1:0] rc_out,
    output logic             rd_valid,
    output logic             rc_valid,
    output logic             td_fresh,
    output logic             tc_fresh,
    output logic             frame_err,
    input  logic             err_clr
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int WW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [WW-1:0] WARM_END = WW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, TX, RX} state_t;

    state_t                      state_q, state_d;
    logic [SYNC_STAGES-1:0]      sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]      sle_sync_q, sle_sync_d;
    logic [SYNC_STAGES-1:0]      sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0][1:0] sel_sync_q, sel_sync_d;
    logic                        sclk_prev_q, sclk_prev_d;
    logic                        sle_prev_q, sle_prev_d;
    logic [WW-1:0]               warm_q, warm_d;
    logic [CW-1:0]               bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]            tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]            rx_sr_q, rx_sr_d;
    logic [1:0]                  cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0]            rd_q, rd_d;
    logic [WIDTH-1:0]            rc_q, rc_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rc_valid_q, rc_valid_d;
    logic                        td_fresh_q, td_fresh_d;
    logic                        tc_fresh_q, tc_fresh_d;
    logic                        err_q, err_d;
    logic                        sdi_q, sdi_d;

    logic             sclk_s, sle_s, sdata_s;
    logic [1:0]       sel_s;
    logic             evt_en, sclk_rise, sle_rise;
    logic             new_err, clr_td, clr_tc;
    logic [WIDTH-1:0] tx_src;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sle_s   = sle_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign sel_s   = sel_sync_q[SYNC_STAGES-1];

    // Edges are masked until the synchronisers have flushed the reset state.
    assign evt_en    = (warm_q == WARM_END);
    assign sclk_rise = evt_en & sclk_s & ~sclk_prev_q;
    assign sle_rise  = evt_en & sle_s & ~sle_prev_q;
    assign tx_src    = sel_s[0] ? tc_in : td_in;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], rpi_sclk};
        sle_sync_d   = {sle_sync_q[SYNC_STAGES-2:0], rpi_sle};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], rpi_sdata_out};
        sel_sync_d   = {sel_sync_q[SYNC_STAGES-2:0], rpi_regsel};
        sclk_prev_d  = sclk_s;
        sle_prev_d   = sle_s;
        warm_d       = evt_en ? warm_q : warm_q + WW'(1);

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        cur_sel_d  = cur_sel_q;
        rd_d       = rd_q;
        rc_d       = rc_q;
        rd_valid_d = 1'b0;
        rc_valid_d = 1'b0;
        new_err    = 1'b0;
        clr_td     = 1'b0;
        clr_tc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sle_rise) begin
                    if (sel_s[1]) begin
                        tx_sr_d   = tx_src;
                        bit_cnt_d = '0;
                        cur_sel_d = sel_s;
                        state_d   = TX;
                    end
                end else if (sclk_rise && !sel_s[1]) begin
                    rx_sr_d   = {rx_sr_q[WIDTH-2:0], sdata_s};
                    bit_cnt_d = CW'(1);
                    cur_sel_d = sel_s;
                    state_d   = RX;
                end
            end
            TX: begin
                if (sel_s != cur_sel_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    new_err   = 1'b1;
                end else if (sle_rise) begin
                    tx_sr_d   = tx_src;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CNT_LAST) begin
                        clr_td    = ~cur_sel_q[0];
                        clr_tc    = cur_sel_q[0];
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            RX: begin
                if (sel_s != cur_sel_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    new_err   = 1'b1;
                end else if (sle_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        rd_d       = cur_sel_q[0] ? rd_q : rx_sr_q;
                        rc_d       = cur_sel_q[0] ? rx_sr_q : rc_q;
                        rd_valid_d = ~cur_sel_q[0];
                        rc_valid_d = cur_sel_q[0];
                    end else begin
                        new_err = 1'b1;
                    end
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        new_err = 1'b1;
                    end else begin
                        rx_sr_d   = {rx_sr_q[WIDTH-2:0], sdata_s};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A TI write landing on the completion clk keeps the flag set.
        td_fresh_d = (td_fresh_q & ~clr_td) | td_strobe;
        tc_fresh_d = (tc_fresh_q & ~clr_tc) | tc_strobe;
        err_d      = (err_q & ~err_clr) | new_err;
        sdi_d      = (state_d == TX) & tx_sr_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            sle_sync_q   <= '0;
            sdata_sync_q <= '0;
            sel_sync_q   <= '0;
            sclk_prev_q  <= 1'b0;
            sle_prev_q   <= 1'b0;
            warm_q       <= '0;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            cur_sel_q    <= '0;
            rd_q         <= '0;
            rc_q         <= '0;
            rd_valid_q   <= 1'b0;
            rc_valid_q   <= 1'b0;
            td_fresh_q   <= 1'b0;
            tc_fresh_q   <= 1'b0;
            err_q        <= 1'b0;
            sdi_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            sle_sync_q   <= sle_sync_d;
            sdata_sync_q <= sdata_sync_d;
            sel_sync_q   <= sel_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            sle_prev_q   <= sle_prev_d;
            warm_q       <= warm_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            cur_sel_q    <= cur_sel_d;
            rd_q         <= rd_d;
            rc_q         <= rc_d;
            rd_valid_q   <= rd_valid_d;
            rc_valid_q   <= rc_valid_d;
            td_fresh_q   <= td_fresh_d;
            tc_fresh_q   <= tc_fresh_d;
            err_q        <= err_d;
            sdi_q        <= sdi_d;
        end
    end

    assign rpi_sdata_in = sdi_q;
    assign rd_out       = rd_q;
    assign rc_out       = rc_q;
    assign rd_valid     = rd_valid_q;
    assign rc_valid     = rc_valid_q;
    assign td_fresh     = td_fresh_q;
    assign tc_fresh     = tc_fresh_q;
    assign frame_err    = err_q;
endmodule
